// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer datapath.
package reaction_pkg;

  typedef enum logic [2:0] {
    SEED,
    IDLE,
    WAIT,
    GO,
    RESULT
  } state_e;

  localparam int RND_MIN              = 2000;
  localparam int RND_MAX              = 15000;
  localparam int DEFAULT_MAX_REACT_MS = 9999;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLKS_PER_MS clocks, restartable by clear.
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == LAST);

  // Count 0..CLKS_PER_MS-1; clear restarts so the first tick lands a full ms later.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/reaction_delay_timer.sv
// One reaction-timer trial: random delay, GO LED, reaction measurement in ms.
//
// state  | meaning
// SEED   | first cycle after reset, pulses lfsr_load
// IDLE   | waiting for the first start press
// WAIT   | counting down the random delay, GO LED off
// GO     | GO LED on, counting reaction milliseconds
// RESULT | outputs hold until the next start press
module reaction_delay_timer
  import reaction_pkg::*;
#(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MAX_REACT_MS = DEFAULT_MAX_REACT_MS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] rnd,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        lfsr_load,
  output logic        go_led,
  output logic [15:0] reaction_ms,
  output logic        result_valid,
  output logic        false_start,
  output logic        timeout,
  output logic        busy
);

  localparam logic [15:0] MAX_MS = 16'(MAX_REACT_MS);

  state_e      state_q;
  logic        lfsr_load_q, go_led_q, result_valid_q, false_start_q, timeout_q, busy_q;
  logic [15:0] reaction_ms_q;
  logic [15:0] delay_cnt_q, react_cnt_q;
  logic        start_prev_q, react_prev_q;

  logic        start_p, react_p, tick, tick_clear;
  logic        enter_wait, enter_go;
  logic [15:0] delay_load_d;

  assign start_p = start_btn & ~start_prev_q;
  assign react_p = react_btn & ~react_prev_q;

  // A zero delay would never terminate the countdown, so it runs as 1 ms.
  assign delay_load_d = (rnd == 16'd0) ? 16'd1 : rnd;

  assign enter_wait = start_p & ((state_q == IDLE) | (state_q == RESULT));
  assign enter_go   = (state_q == WAIT) & tick & ~react_p & (delay_cnt_q <= 16'd1);
  assign tick_clear = enter_wait | enter_go;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .clear(tick_clear),
    .tick (tick)
  );

  // Button history; reset to 1 so a button held through reset produces no edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_prev_q <= 1'b1;
      react_prev_q <= 1'b1;
    end else begin
      start_prev_q <= start_btn;
      react_prev_q <= react_btn;
    end
  end

  // Trial sequencing with registered outputs; react_p takes priority over a same-cycle tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= SEED;
      lfsr_load_q    <= 1'b1;
      go_led_q       <= 1'b0;
      reaction_ms_q  <= '0;
      result_valid_q <= 1'b0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      delay_cnt_q    <= '0;
      react_cnt_q    <= '0;
    end else begin
      case (state_q)
        SEED: begin
          lfsr_load_q <= 1'b0;
          state_q     <= IDLE;
        end
        IDLE, RESULT: begin
          if (enter_wait) begin
            delay_cnt_q    <= delay_load_d;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= WAIT;
          end
        end
        WAIT: begin
          if (react_p) begin
            false_start_q <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= RESULT;
          end else if (enter_go) begin
            go_led_q    <= 1'b1;
            react_cnt_q <= '0;
            state_q     <= GO;
          end else if (tick) begin
            delay_cnt_q <= delay_cnt_q - 16'd1;
          end
        end
        GO: begin
          if (react_p) begin
            reaction_ms_q  <= react_cnt_q;
            result_valid_q <= 1'b1;
            go_led_q       <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= RESULT;
          end else if (tick) begin
            if (react_cnt_q >= MAX_MS - 16'd1) begin
              reaction_ms_q  <= MAX_MS;
              timeout_q      <= 1'b1;
              result_valid_q <= 1'b0;
              go_led_q       <= 1'b0;
              busy_q         <= 1'b0;
              state_q        <= RESULT;
            end else begin
              react_cnt_q <= react_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= SEED;
      endcase
    end
  end

  assign lfsr_load    = lfsr_load_q;
  assign go_led       = go_led_q;
  assign reaction_ms  = reaction_ms_q;
  assign result_valid = result_valid_q;
  assign false_start  = false_start_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Bench for reaction_delay_timer: cycle-count reference model plus directed literal checks.
module tb_reaction_delay_timer;

  localparam int CPM  = 4;
  localparam int MAXR = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rnd = 16'd2000;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic        lfsr_load, go_led, result_valid, false_start, timeout, busy;
  logic [15:0] reaction_ms;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clock = ~clock;

  reaction_delay_timer #(
    .CLKS_PER_MS (CPM),
    .MAX_REACT_MS(MAXR)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rnd         (rnd),
    .start_btn   (start_btn),
    .react_btn   (react_btn),
    .lfsr_load   (lfsr_load),
    .go_led      (go_led),
    .reaction_ms (reaction_ms),
    .result_valid(result_valid),
    .false_start (false_start),
    .timeout     (timeout),
    .busy        (busy)
  );

  // Reference model: phases tracked by elapsed cycle counts, not by a prescaler.
  // 0 seed, 1 idle, 2 waiting, 3 go, 4 result
  int          m_phase = 0;
  int          m_cnt = 0;
  int          m_target = 0;
  bit          m_prev_s = 1'b1, m_prev_r = 1'b1, m_ready = 1'b0;
  logic        e_load, e_go, e_valid, e_fs, e_to, e_busy;
  logic [15:0] e_ms;

  always @(posedge clock) begin
    bit sp, rp;
    int k;
    cyc++;
    if (reset) begin
      m_phase = 0; e_load = 1'b1; e_go = 1'b0; e_ms = 16'd0;
      e_valid = 1'b0; e_fs = 1'b0; e_to = 1'b0; e_busy = 1'b0;
      m_prev_s = 1'b1; m_prev_r = 1'b1; m_ready = 1'b1;
    end else begin
      sp = start_btn && !m_prev_s;
      rp = react_btn && !m_prev_r;
      m_prev_s = start_btn;
      m_prev_r = react_btn;
      case (m_phase)
        0: begin m_phase = 1; e_load = 1'b0; end
        1, 4: if (sp) begin
          m_target = ((rnd == 16'd0) ? 1 : int'(rnd)) * CPM;
          m_cnt = 0; e_valid = 1'b0; e_fs = 1'b0; e_to = 1'b0; e_busy = 1'b1;
          m_phase = 2;
        end
        2: begin
          m_cnt++;
          if (rp) begin
            m_phase = 4; e_fs = 1'b1; e_busy = 1'b0;
          end else if (m_cnt == m_target) begin
            m_phase = 3; e_go = 1'b1; m_cnt = 0;
          end
        end
        3: begin
          k = m_cnt;
          m_cnt++;
          if (rp) begin
            e_ms = 16'(k / CPM); e_valid = 1'b1; e_go = 1'b0; e_busy = 1'b0; m_phase = 4;
          end else if (m_cnt == MAXR * CPM) begin
            e_ms = 16'(MAXR); e_to = 1'b1; e_valid = 1'b0; e_go = 1'b0; e_busy = 1'b0; m_phase = 4;
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_ready) begin
      checks++;
      if ({lfsr_load, go_led, result_valid, false_start, timeout, busy, reaction_ms} !==
          {e_load, e_go, e_valid, e_fs, e_to, e_busy, e_ms}) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model_cycle cyc=%0d got load=%b go=%b val=%b fs=%b to=%b busy=%b ms=%0d expected load=%b go=%b val=%b fs=%b to=%b busy=%b ms=%0d",
                   cyc, lfsr_load, go_led, result_valid, false_start, timeout, busy, reaction_ms,
                   e_load, e_go, e_valid, e_fs, e_to, e_busy, e_ms);
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start_pulse();
    start_btn = 1'b1;
    tick_n(1);
    start_btn = 1'b0;
  endtask

  task automatic wait_go(input int lim);
    int n;
    n = 0;
    while (!go_led && n < lim) begin
      tick_n(1);
      n++;
    end
    checks++;
    if (!go_led) begin
      errors++;
      $display("FAIL go_wait: go_led still %b after %0d cycles, expected 1", go_led, lim);
    end
  endtask

  initial begin
    int start_cyc, go_cyc;
    bit seen_go;

    // Reset and seed pulse
    tick_n(3);
    check("reset_lfsr_load", int'(lfsr_load), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_reaction_ms", int'(reaction_ms), 0);
    reset = 1'b0;
    tick_n(1);
    check("seed_one_cycle", int'(lfsr_load), 0);
    check("idle_outputs", int'({go_led, result_valid, false_start, timeout, busy}), 0);

    // Nominal trial: delay 2000 ms, reaction of 137 ms
    rnd = 16'd2000;
    start_pulse();
    start_cyc = cyc;
    check("wait_busy", int'(busy), 1);
    wait_go(9000);
    check("go_delay_cycles", cyc - start_cyc, 8000);
    go_cyc = cyc;
    tick_n(4 * 137 + 2);
    react_btn = 1'b1;
    tick_n(1);
    check("react_ms_137", int'(reaction_ms), 137);
    check("react_valid", int'(result_valid), 1);
    check("react_go_off", int'(go_led), 0);
    react_btn = 1'b0;
    tick_n(2);

    // False start
    rnd = 16'd5000;
    start_pulse();
    tick_n(99);
    react_btn = 1'b1;
    tick_n(1);
    react_btn = 1'b0;
    check("fs_flag", int'(false_start), 1);
    check("fs_ms_kept", int'(reaction_ms), 137);
    check("fs_valid_cleared", int'(result_valid), 0);
    seen_go = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
      if (go_led) seen_go = 1'b1;
    end
    check("fs_no_go", int'(seen_go), 0);

    // Timeout at MAXR ms
    rnd = 16'd2000;
    start_pulse();
    wait_go(9000);
    tick_n(MAXR * CPM - 1);
    check("pre_timeout_go", int'({go_led, timeout}), 2);
    tick_n(1);
    check("timeout_flag", int'(timeout), 1);
    check("timeout_ms", int'(reaction_ms), MAXR);
    check("timeout_valid", int'(result_valid), 0);
    check("timeout_go_off", int'(go_led), 0);

    // Held react button, release and re-press in GO, ignored start mid-GO
    react_btn = 1'b1;
    tick_n(2);
    start_pulse();
    wait_go(9000);
    tick_n(10);
    check("held_no_result", int'({go_led, result_valid, false_start}), 4);
    react_btn = 1'b0;
    tick_n(40);
    start_pulse();
    tick_n(70);
    react_btn = 1'b1;
    tick_n(1);
    check("repress_ms_30", int'(reaction_ms), 30);
    check("repress_valid", int'(result_valid), 1);
    react_btn = 1'b0;
    tick_n(2);

    // Reset in the middle of GO
    rnd = 16'd1;
    start_pulse();
    wait_go(20);
    tick_n(5);
    reset = 1'b1;
    tick_n(1);
    check("midreset_outputs", int'({lfsr_load, go_led, busy}), 4);
    check("midreset_ms", int'(reaction_ms), 0);
    reset = 1'b0;
    tick_n(2);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      @(negedge clock);
      rnd = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 399) == 0) react_btn = ~react_btn;
      reset = ($urandom_range(0, 2999) == 0);
    end
    reset = 1'b0;
    tick_n(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
